// File: rtl/nes_controller_emulator.sv
`timescale 1ns/1ps
// nes_controller_emulator
//
// Emulates the serial side of an NES joypad. The console drives nesLatch and
// nesDataClk asynchronously to clk. While the latch is high the shift register
// tracks the live (inverted) button levels. On the latch falling edge the
// register freezes. Each data-clock rising edge then shifts one button onto
// nesData.
//
// Parameters
//   SYNC_STAGES  synchroniser depth on nesLatch / nesDataClk (legal 2..4)
//   FILL_BIT     level shifted in behind the 8 buttons, and driven when idle
//
// Ports
//   clk                  system clock, much faster than nesDataClk
//   reset                asynchronous active-low reset
//   nesLatch, nesDataClk console strobes, asynchronous to clk
//   nesData              registered serial data, low = pressed
//   A..right             live button levels, high = pressed
//   frameDone            one-cycle pulse when the 8th bit has been shifted out
//   busy                 high while in LOAD or SHIFT
//   latchCount           count of latch rising edges, wraps at 16 bits
module nes_controller_emulator #(
    parameter int SYNC_STAGES = 2,
    parameter bit FILL_BIT    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        nesLatch,
    input  logic        nesDataClk,
    output logic        nesData,
    input  logic        A,
    input  logic        B,
    input  logic        select,
    input  logic        start,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    output logic        frameDone,
    output logic        busy,
    output logic [15:0] latchCount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    logic [1:0]             run_sync_reg;
    logic                   run;
    logic [SYNC_STAGES-1:0] latch_sync_reg;
    logic [SYNC_STAGES-1:0] dclk_sync_reg;
    logic                   latch_prev_reg;
    logic                   dclk_prev_reg;
    logic                   latch_s;
    logic                   dclk_s;
    logic                   latch_rise;
    logic                   latch_fall;
    logic                   dclk_rise;
    state_t                 state_reg;
    state_t                 state_next;
    logic [7:0]             buttons;
    logic [7:0]             load_vec;
    logic [7:0]             shift_reg;
    logic [7:0]             shift_next;
    logic [3:0]             bit_cnt_reg;
    logic [3:0]             bit_cnt_next;
    logic [15:0]            latch_count_reg;
    logic [15:0]            latch_count_next;
    logic                   nes_data_reg;
    logic                   nes_data_next;
    logic                   frame_done_reg;
    logic                   frame_done_next;
    logic                   busy_reg;
    logic                   busy_next;

    // Bit 0 is A, so it is the first bit presented on nesData.
    assign buttons = {right, left, down, up, start, select, B, A};

    // The wire protocol is active-low: a pressed button reads as 0.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_load
            assign load_vec[gi] = ~buttons[gi];
        end
    endgenerate

    // Reset release is retimed through two flops. All other state holds its
    // reset value until run rises. As a result, nothing changes before the
    // second clk edge after reset deasserts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_sync_reg <= 2'b00;
        end else begin
            run_sync_reg <= {run_sync_reg[0], 1'b1};
        end
    end
    assign run = run_sync_reg[1];

    assign latch_s    = latch_sync_reg[SYNC_STAGES-1];
    assign dclk_s     = dclk_sync_reg[SYNC_STAGES-1];
    assign latch_rise = latch_s & ~latch_prev_reg;
    assign latch_fall = ~latch_s & latch_prev_reg;
    assign dclk_rise  = dclk_s & ~dclk_prev_reg;

    // State register process (also holds the synchronisers and the datapath).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            latch_sync_reg  <= '0;
            dclk_sync_reg   <= '0;
            latch_prev_reg  <= 1'b0;
            dclk_prev_reg   <= 1'b0;
            state_reg       <= IDLE;
            shift_reg       <= '1;
            bit_cnt_reg     <= 4'd0;
            latch_count_reg <= 16'd0;
            nes_data_reg    <= 1'b1;
            frame_done_reg  <= 1'b0;
            busy_reg        <= 1'b0;
        end else if (run) begin
            latch_sync_reg  <= {latch_sync_reg[SYNC_STAGES-2:0], nesLatch};
            dclk_sync_reg   <= {dclk_sync_reg[SYNC_STAGES-2:0], nesDataClk};
            latch_prev_reg  <= latch_s;
            dclk_prev_reg   <= dclk_s;
            state_reg       <= state_next;
            shift_reg       <= shift_next;
            bit_cnt_reg     <= bit_cnt_next;
            latch_count_reg <= latch_count_next;
            nes_data_reg    <= nes_data_next;
            frame_done_reg  <= frame_done_next;
            busy_reg        <= busy_next;
        end
    end

    // Next-state logic. A latch rising edge outranks everything, including a
    // data-clock edge detected in the same cycle. DONE and IDLE are left only
    // by a new latch.
    always_comb begin
        state_next = state_reg;
        if (latch_rise) begin
            state_next = LOAD;
        end else begin
            case (state_reg)
                LOAD:    if (latch_fall) state_next = SHIFT;
                SHIFT:   if (dclk_rise && bit_cnt_reg == 4'd7) state_next = DONE;
                default: state_next = state_reg;
            endcase
        end
    end

    // Output and datapath logic.
    always_comb begin
        shift_next       = shift_reg;
        bit_cnt_next     = bit_cnt_reg;
        latch_count_next = latch_count_reg;
        if (latch_rise) begin
            // Loading on the entry cycle puts ~A on nesData without an
            // extra cycle of delay. The bit counter is left alone here and
            // is cleared when the latch falls.
            shift_next       = load_vec;
            latch_count_next = latch_count_reg + 16'd1;
        end else begin
            case (state_reg)
                LOAD: begin
                    // On the falling edge, keep the previous cycle's load.
                    // The buttons sampled then are the ones the frame carries.
                    if (latch_fall) bit_cnt_next = 4'd0;
                    else            shift_next   = load_vec;
                end
                SHIFT: begin
                    if (dclk_rise) begin
                        shift_next   = {FILL_BIT, shift_reg[7:1]};
                        bit_cnt_next = (bit_cnt_reg >= 4'd8) ? 4'd8 : bit_cnt_reg + 4'd1;
                    end
                end
                default: shift_next = shift_reg;
            endcase
        end
        busy_next       = (state_next == LOAD) || (state_next == SHIFT);
        frame_done_next = (state_reg == SHIFT) && (state_next == DONE);
        nes_data_next   = busy_next ? shift_next[0] : FILL_BIT;
    end

    assign nesData    = nes_data_reg;
    assign frameDone  = frame_done_reg;
    assign busy       = busy_reg;
    assign latchCount = latch_count_reg;

endmodule

// File: tb/tb_nes_controller_emulator.sv
`timescale 1ns/1ps
module tb_nes_controller_emulator;

    localparam int SYNC  = 2;
    localparam bit FILL  = 1'b1;
    localparam int WIN   = SYNC + 5;   // cycles during which old or new output is acceptable
    localparam int HOLD  = WIN + 4;    // cycles each pin level is held
    localparam int S_IDLE = 0, S_LOAD = 1, S_SHIFT = 2, S_DONE = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        latch_pin;
    logic        dclk_pin;
    logic [7:0]  btn;
    logic        nesData;
    logic        frameDone;
    logic        busy;
    logic [15:0] latchCount;

    always #5 clk = ~clk;

    nes_controller_emulator #(.SYNC_STAGES(SYNC), .FILL_BIT(FILL)) dut (
        .clk        (clk),
        .reset      (reset_n),
        .nesLatch   (latch_pin),
        .nesDataClk (dclk_pin),
        .nesData    (nesData),
        .A          (btn[0]),
        .B          (btn[1]),
        .select     (btn[2]),
        .start      (btn[3]),
        .up         (btn[4]),
        .down       (btn[5]),
        .left       (btn[6]),
        .right      (btn[7]),
        .frameDone  (frameDone),
        .busy       (busy),
        .latchCount (latchCount)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int last_ev  = -1000;
    int dut_fd   = 0;
    logic prev_fd = 1'b0;

    // Behavioural model: protocol state reacting to pin events.
    int          m_state;
    logic [7:0]  m_bits;
    int          m_cnt;
    int          m_fd;
    logic [15:0] m_count;
    logic        exp_data, old_data, exp_busy, old_busy;
    logic [15:0] old_count;

    function automatic logic model_data();
        if (m_state == S_LOAD)  return ~btn[0];
        if (m_state == S_SHIFT) return m_bits[0];
        return FILL;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_tol(input string name, input logic [31:0] act, input logic [31:0] cur,
                           input logic [31:0] old, input bit win);
        n_checks++;
        if (!(act === cur || (win && act === old))) begin
            n_errors++;
            $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, cur);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        bit win;
        cyc++;
        if (!reset_n) begin
            chk("reset nesData", nesData, 1);
            chk("reset busy", busy, 0);
            chk("reset frameDone", frameDone, 0);
            chk("reset latchCount", latchCount, 0);
        end else begin
            win = (cyc - last_ev) <= WIN;
            chk_tol("nesData", nesData, exp_data, old_data, win);
            chk_tol("busy", busy, exp_busy, old_busy, win);
            chk_tol("latchCount", latchCount, m_count, old_count, win);
            if (frameDone) begin
                dut_fd++;
                chk("frameDone width", prev_fd, 0);
            end
        end
        prev_fd = frameDone;
    end

    // Change pins, advance the model, and hold the new levels.
    task automatic step(input logic nl, input logic nd, input logic [7:0] nb);
        @(posedge clk);
        #2;
        old_data  = exp_data;
        old_busy  = exp_busy;
        old_count = m_count;
        if (nl && !latch_pin) begin
            m_state = S_LOAD;
            m_count = m_count + 16'd1;
        end else if (!nl && latch_pin && m_state == S_LOAD) begin
            m_bits  = ~btn;
            m_cnt   = 0;
            m_state = S_SHIFT;
        end else if (nd && !dclk_pin && m_state == S_SHIFT) begin
            m_bits = {FILL, m_bits[7:1]};
            m_cnt++;
            if (m_cnt == 8) begin
                m_state = S_DONE;
                m_fd++;
            end
        end
        latch_pin = nl;
        dclk_pin  = nd;
        btn       = nb;
        exp_data  = model_data();
        exp_busy  = (m_state == S_LOAD) || (m_state == S_SHIFT);
        last_ev   = cyc;
        repeat (HOLD) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_state  = S_IDLE;
        m_bits   = 8'hFF;
        m_cnt    = 0;
        m_count  = 16'd0;
        exp_data = 1'b1;
        exp_busy = 1'b0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        reset_n   = 1'b1;
        old_data  = 1'b1;
        old_busy  = 1'b0;
        old_count = 16'd0;
        if (latch_pin) begin
            m_state = S_LOAD;
            m_count = m_count + 16'd1;
        end
        exp_data = model_data();
        exp_busy = (m_state == S_LOAD) || (m_state == S_SHIFT);
        last_ev  = cyc;
        repeat (HOLD) @(posedge clk);
        #1;
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("async reset nesData", nesData, 1);
        chk("async reset busy", busy, 0);
        chk("async reset frameDone", frameDone, 0);
        chk("async reset latchCount", latchCount, 0);
        repeat (3) @(posedge clk);
        release_reset();
    endtask

    // Sample nesData before each data-clock pulse; seq[i] is bit i.
    task automatic shift_bits(input int n, input logic [7:0] b, output logic [15:0] seq);
        seq = '1;
        for (int i = 0; i < n; i++) begin
            seq[i] = nesData;
            step(1'b0, 1'b1, b);
            step(1'b0, 1'b0, b);
        end
    endtask

    task automatic latch_frame(input logic [7:0] b);
        step(1'b0, 1'b0, b);
        step(1'b1, 1'b0, b);
        step(1'b0, 1'b0, b);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] seq;
        logic [7:0]  b;
        int          n;
        int          fd0;

        reset_n   = 1'b0;
        latch_pin = 1'b0;
        dclk_pin  = 1'b0;
        btn       = 8'h00;
        m_fd      = 0;
        old_data  = 1'b1;
        old_busy  = 1'b0;
        old_count = 16'd0;
        model_reset();
        repeat (4) @(posedge clk);
        release_reset();

        // Full frame with A and right pressed.
        $display("scenario: full frame A+right");
        fd0 = dut_fd;
        latch_frame(8'h81);
        chk("frame1 latchCount", latchCount, 16'd1);
        shift_bits(8, 8'h81, seq);
        chk("frame1 bits", seq[7:0], 8'h7E);
        chk("frame1 frameDone", dut_fd - fd0, 1);

        // Ten clocks, nothing pressed.
        $display("scenario: ten clocks, no buttons");
        fd0 = dut_fd;
        latch_frame(8'h00);
        shift_bits(10, 8'h00, seq);
        chk("ten clocks bits", seq[9:0], 10'h3FF);
        chk("ten clocks frameDone", dut_fd - fd0, 1);

        // Frame abort after 3 clocks; new frame with start pressed.
        $display("scenario: frame abort");
        latch_frame(8'h00);
        shift_bits(3, 8'h00, seq);
        fd0 = dut_fd;
        latch_frame(8'h08);
        chk("abort no frameDone", dut_fd - fd0, 0);
        shift_bits(8, 8'h08, seq);
        chk("abort frame bits", seq[7:0], 8'hF7);
        chk("abort frame frameDone", dut_fd - fd0, 1);

        // Simultaneous latch and data-clock rising edges.
        $display("scenario: simultaneous edges");
        latch_frame(8'h01);
        shift_bits(2, 8'h01, seq);
        fd0 = dut_fd;
        step(1'b1, 1'b1, 8'h01);
        chk("simul busy", busy, 1);
        chk("simul nesData", nesData, 0);
        step(1'b0, 1'b0, 8'h01);
        shift_bits(7, 8'h01, seq);
        chk("simul no early frameDone", dut_fd - fd0, 0);
        shift_bits(1, 8'h01, seq);
        chk("simul frameDone", dut_fd - fd0, 1);

        // B released after bit 0: frame keeps B as latched.
        $display("scenario: button change mid-shift");
        latch_frame(8'h02);
        chk("midshift bit0", nesData, 1);
        step(1'b0, 1'b1, 8'h02);
        step(1'b0, 1'b0, 8'h00);
        shift_bits(7, 8'h00, seq);
        chk("midshift bits1-7", seq[6:0], 7'h7E);

        // Reset in the middle of a frame.
        $display("scenario: reset mid-shift");
        latch_frame(8'h00);
        shift_bits(4, 8'h00, seq);
        async_reset();
        fd0 = dut_fd;
        latch_frame(8'h81);
        chk("post-reset latchCount", latchCount, 16'd1);
        shift_bits(8, 8'h81, seq);
        chk("post-reset bits", seq[7:0], 8'h7E);
        chk("post-reset frameDone", dut_fd - fd0, 1);

        // Counter wrap: preload to 0xFFFF latches, then one more.
        $display("scenario: latchCount wrap");
        @(posedge clk);
        #2;
        force dut.latch_count_reg = 16'hFFFF;
        old_count = m_count;
        m_count   = 16'hFFFF;
        last_ev   = cyc;
        repeat (2) @(posedge clk);
        #2;
        release dut.latch_count_reg;
        repeat (HOLD) @(posedge clk);
        latch_frame(8'h00);
        chk("latchCount wrap", latchCount, 16'd0);
        shift_bits(8, 8'h00, seq);

        // Latch held high across reset release is seen as a rising edge.
        $display("scenario: latch high at reset release");
        step(1'b1, 1'b0, 8'h01);
        async_reset();
        chk("release latchCount", latchCount, 16'd1);
        chk("release busy", busy, 1);
        chk("release nesData", nesData, 0);
        step(1'b0, 1'b0, 8'h01);
        shift_bits(8, 8'h01, seq);
        chk("release frame bits", seq[7:0], 8'hFE);

        // Randomised frames against the model.
        for (int f = 0; f < 30; f++) begin
            b = 8'($urandom);
            n = $urandom_range(0, 10);
            step(1'b0, 1'b0, b);
            step(1'b1, 1'b0, b);
            if ($urandom_range(0, 2) == 0) begin
                b = 8'($urandom);
                step(1'b1, 1'b0, b);
            end
            step(1'b0, 1'b0, b);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) b = 8'($urandom);
                step(1'b0, 1'b1, b);
                step(1'b0, 1'b0, b);
            end
            if ($urandom_range(0, 4) == 0) begin
                step(1'b1, 1'b1, b);
                step(1'b0, 1'b0, b);
            end
            chk("frameDone pulses", dut_fd, m_fd);
            $display("frame %0d: buttons %02h clocks %0d latchCount %0d", f, b, n, latchCount);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nes_controller_emulator.md
NES_CONTROLLER_EMULATOR -- requirements
Module: nes_controller_emulator

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets the synchroniser depth on nesLatch and nesDataClk; legal values are 2 to 4.
REQ-002 Parameter FILL_BIT, default 1, sets the level driven on nesData after all 8 buttons are shifted out.
REQ-003 The block SHALL have the following ports:
- clk  input  1  system clock; all state changes on its rising edge; much faster than nesDataClk.
- reset  input  1  asynchronous, active-low reset.
- nesLatch  input  1  latch from console; asynchronous to clk.
- nesDataClk  input  1  data clock from console; asynchronous to clk.
- nesData  output  1  serial button data, registered; low = pressed.
- A, B, select, start, up, down, left, right  input  1 each  live button state; high = pressed.
- frameDone  output  1  one-cycle pulse when the 8th button bit has been shifted out.
- busy  output  1  high in states LOAD and SHIFT.
- latchCount  output  16  count of latch rising edges; wraps from 0xFFFF to 0.

Function
REQ-004 nesLatch and nesDataClk SHALL each pass through SYNC_STAGES flops, then a one-flop edge detector; internal logic SHALL use only the synchronised signals.
REQ-005 The FSM SHALL have states IDLE, LOAD, SHIFT and DONE.
REQ-006 A synchronised latch rising edge in any state SHALL move the FSM to LOAD and increment latchCount.
REQ-007 While in LOAD, the block SHALL parallel-load the 8-bit shift register every clk cycle with inverted buttons, in order A,B,select,start,up,down,left,right (A first); nesData SHALL equal the inverted A of the latest load.
REQ-008 A synchronised latch falling edge in LOAD SHALL freeze the register contents, clear the bit counter to 0, and move the FSM to SHIFT.
REQ-009 Each synchronised nesDataClk rising edge in SHIFT SHALL shift the register by one bit, shift FILL_BIT into the vacated position, and increment the bit counter.
REQ-010 nesData SHALL present the new head bit on the clk cycle following the detected edge.
REQ-011 End-to-end latency from a pin transition to the nesData update SHALL be SYNC_STAGES+2 clk cycles, with ±1 cycle for metastability.
REQ-012 On the 8th shift (counter 7 to 8), the FSM SHALL enter DONE and frameDone SHALL pulse high for exactly one cycle.
REQ-013 In DONE, nesData SHALL equal FILL_BIT; further nesDataClk edges SHALL leave nesData at FILL_BIT and SHALL NOT pulse frameDone.
REQ-014 In IDLE, nesData SHALL equal FILL_BIT, and nesDataClk edges SHALL be ignored.
REQ-015 nesDataClk edges in LOAD SHALL be ignored, because parallel load dominates.
REQ-016 If a latch rising edge and a nesDataClk rising edge are detected in the same cycle, the latch edge SHALL win and the clock edge SHALL be discarded.
REQ-017 A latch rising edge in SHIFT (a frame abort) SHALL enter LOAD without pulsing frameDone.
REQ-018 Button inputs SHALL affect nesData only while in LOAD; button changes during SHIFT or DONE SHALL NOT alter the frame in progress.
REQ-019 The bit counter SHALL be 4 bits wide and SHALL saturate at 8.

Reset
REQ-020 While reset is low: FSM = IDLE, shift register = all ones, bit counter = 0, nesData = 1, frameDone = 0, busy = 0, latchCount = 0, and all synchroniser and edge flops = 0.
REQ-021 Reset assertion SHALL take effect immediately without clk; deassertion SHALL be synchronised, so the first state change occurs on or after the 2nd clk edge following deassertion.
REQ-022 A latch high level present at reset release SHALL be detected as a rising edge once it has propagated through the synchronisers.

Verification
REQ-023 The bench SHALL cover the following scenarios:
- Full frame, A and right pressed, others released: latch pulse, then 8 clocks → nesData sequence 0,1,1,1,1,1,1,0; frameDone pulses once after the 8th edge; latchCount = 1.
- 10 clocks after one latch, no buttons pressed, FILL_BIT = 1 → nesData reads 1 for all 10 bits; frameDone pulses exactly once.
- Frame abort: latch, 3 clocks, new latch with start pressed → no frameDone pulse; new frame begins with A, and the 4th bit is 0.
- Simultaneous latch and data-clock rising edges in the same synchronised cycle → FSM = LOAD; bit counter unchanged; nesData = inverted A.
- Button change mid-SHIFT: B toggles after bit 0 → the frame output reflects B as sampled at latch fall.
- Reset asserted mid-SHIFT at bit 4 → outputs immediately at reset values; after release, the next latch starts a clean frame; latchCount restarts at 0; 0xFFFF latches then one more → latchCount = 0.
